wave_gen: RTL and testbench
===========================

WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 SHALL have parameter N, default 8, meaning output sample width.
REQ-002 SHALL have parameter PHASE_W, default 24, meaning phase accumulator width.
REQ-003 SHALL have parameter FRE_DIV, default 2499, meaning a sample tick occurs every FRE_DIV+1 clocks.
REQ-004 SHALL have port clk, input, 1, the single 50 MHz system clock.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a one-clock request to begin generation.
REQ-007 SHALL have port stop, input, 1, a one-clock request to end generation at the next period boundary.
REQ-008 SHALL have port freq_word, input, PHASE_W, the phase increment per sample.
REQ-009 SHALL have port amplitude, input, 8, the unsigned peak amplitude in LSB.
REQ-010 SHALL have port dc_offset, input, 8, the unsigned DC level in LSB.
REQ-011 SHALL have port wave_sel, input, 1, where 0 selects sine and 1 selects square.
REQ-012 SHALL have port sample_en, output, 1, a one-clock sample tick.
REQ-013 SHALL have port data_out_unsigned, output, N, the unsigned waveform sample.
REQ-014 SHALL have port data_valid, output, 1, a one-clock strobe for a new data_out_unsigned.
REQ-015 SHALL have port busy, output, 1, asserted in RUN and STOPPING.

Function
REQ-016 SHALL implement the states IDLE, RUN and STOPPING.
REQ-017 SHALL, in IDLE with start=1: latch freq_word, amplitude, dc_offset and wave_sel; clear the phase and the tick counter; and enter RUN.
REQ-018 SHALL ignore start while in RUN or STOPPING.
REQ-019 SHALL, on stop=1 in RUN, enter STOPPING; stop SHALL be ignored in IDLE and STOPPING.
REQ-020 SHALL, when start and stop are both high in IDLE, act on start only.
REQ-021 SHALL count ticks from 0 to FRE_DIV while busy and assert sample_en for one clock when the count equals FRE_DIV; the count SHALL then wrap to 0.
REQ-022 SHALL, on each sample_en, register the LUT/square lookup from the current phase and then add the latched freq_word to the phase, modulo 2^PHASE_W.
REQ-023 SHALL assert data_out_unsigned and data_valid 2 clocks after sample_en, which gives a fixed 2-clock latency; the first sample after start SHALL use phase 0.
REQ-024 SHALL form the sine index k from phase[PHASE_W-1 -: 8], use a 65-entry quarter table s(k)=round(127*sin(2*pi*k/256)) for k=0..64, and mirror the other quadrants to the signed range -127..127.
REQ-025 SHALL compute the sine output as dc_offset + ((amplitude*s) >>> 7), with arithmetic shift and floor, in a signed width of 10 bits or more.
REQ-026 SHALL compute the square output as dc_offset+amplitude when the phase MSB is 0, and dc_offset-amplitude otherwise.
REQ-027 SHALL saturate the result to the range 0..255 before registering it.
REQ-028 SHALL reload freq_word, amplitude, dc_offset and wave_sel from the inputs only at a phase wrap (carry out of the accumulator), so that parameter changes take effect at period boundaries only.
REQ-029 SHALL, in STOPPING, keep generating until the phase wrap, then enter IDLE, drive data_out_unsigned to the latched dc_offset, and drop busy.
REQ-030 SHALL hold data_out_unsigned in IDLE, with sample_en and data_valid held low.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-operation, immediately reset: state to IDLE; phase, tick counter and all latched parameters to 0; and sample_en, data_valid, busy and data_out_unsigned to 0.
REQ-032 SHALL, after rst_n rises, stay in IDLE until the next start.

Configuration
REQ-033 SHALL generate the square wave per REQ-026 when the macro WAVE_GEN_SQUARE_EN is defined.
REQ-034 SHALL, without WAVE_GEN_SQUARE_EN, exclude the square logic, ignore wave_sel, and always generate the sine wave.

Verification (FRE_DIV=4, freq_word=24'h080000, so 32 samples per period)
REQ-035 SHALL cover: sine with amplitude=25 and dc_offset=40 -> sample 0 = 40, sample 8 = 64, sample 24 = 15, and data_valid every 5 clocks.
REQ-036 SHALL cover: sine with amplitude=200 and dc_offset=200 -> sample 8 = 255 (saturated), sample 24 = 1.
REQ-037 SHALL cover, with WAVE_GEN_SQUARE_EN defined: wave_sel=1, amplitude=40, dc_offset=40 -> samples 0-15 = 80 and samples 16-31 = 0; without the macro, the same stimulus SHALL give the sine values of REQ-035's waveform scaled by amplitude 40.
REQ-038 SHALL cover: stop at sample 10 -> samples 11-31 still emitted, then busy=0 and data_out_unsigned=40 held.
REQ-039 SHALL cover: amplitude changed from 25 to 13 at sample 5 -> that period stays unchanged and the next period's sample 8 = 52.
REQ-040 SHALL cover: rst_n pulsed low mid-RUN -> all outputs read 0 in the same clock, and no sample_en appears until a new start.

Source files
------------

// File: rtl/wave_gen.sv
// wave_gen: tick-divided DDS waveform source, sine by default; square output compiled in with WAVE_GEN_SQUARE_EN.
// Latency: data_out_unsigned/data_valid follow sample_en by 2 clocks; one sample every FRE_DIV+1 clocks while busy.
// Backpressure: none, samples free-run at the tick rate; stop lets the current period finish before idling.
module wave_gen #(
  parameter int N       = 8,
  parameter int PHASE_W = 24,
  parameter int FRE_DIV = 2499
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [7:0]         amplitude,
  input  logic [7:0]         dc_offset,
  input  logic               wave_sel,
  output logic               sample_en,
  output logic [N-1:0]       data_out_unsigned,
  output logic               data_valid,
  output logic               busy
);

  localparam int CNT_W = (FRE_DIV > 0) ? $clog2(FRE_DIV + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load_start;
  logic                w_load_wrap;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_tick;
  logic                w_wrap;
  logic [PHASE_W-1:0]  r_phase;
  logic [PHASE_W:0]    w_phase_sum;
  logic [PHASE_W-1:0]  r_fw;
  logic [7:0]          r_amp;
  logic [7:0]          r_dc;

  // sine lookup path
  logic [7:0]          w_idx;
  logic [6:0]          w_qk;
  logic [6:0]          w_mag;
  logic signed [7:0]   w_lut;

  // first pipeline stage: lookup result plus the parameters it belongs to
  logic                r_s1_vld;
  logic signed [7:0]   r_s1_sin;
  logic [7:0]          r_s1_amp;
  logic [7:0]          r_s1_dc;

  // second stage arithmetic
  logic signed [16:0]  w_amp_x;
  logic signed [16:0]  w_sin_x;
  logic signed [16:0]  w_prod;
  logic signed [16:0]  w_scaled;
  logic signed [16:0]  w_sin_val;
  logic signed [16:0]  w_val;
  logic [7:0]          w_sat;
  logic [7:0]          r_dout;
  logic                r_dv;

`ifdef WAVE_GEN_SQUARE_EN
  logic                r_sel;
  logic                r_s1_sq;
  logic                r_s1_msb;
  logic signed [16:0]  w_sq_val;
`else
  logic                w_unused_sel;
  assign w_unused_sel = wave_sel;
`endif

  // Quarter-wave table: round(127*sin(2*pi*k/256)) for k = 0..64.
  function automatic logic [6:0] f_quarter(input logic [6:0] k);
    logic [6:0] q;
    q = 7'd0;
    case (k)
      7'd0:  q = 7'd0;    7'd1:  q = 7'd3;    7'd2:  q = 7'd6;    7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;   7'd5:  q = 7'd16;   7'd6:  q = 7'd19;   7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;   7'd9:  q = 7'd28;   7'd10: q = 7'd31;   7'd11: q = 7'd34;
      7'd12: q = 7'd37;   7'd13: q = 7'd40;   7'd14: q = 7'd43;   7'd15: q = 7'd46;
      7'd16: q = 7'd49;   7'd17: q = 7'd51;   7'd18: q = 7'd54;   7'd19: q = 7'd57;
      7'd20: q = 7'd60;   7'd21: q = 7'd63;   7'd22: q = 7'd65;   7'd23: q = 7'd68;
      7'd24: q = 7'd71;   7'd25: q = 7'd73;   7'd26: q = 7'd76;   7'd27: q = 7'd78;
      7'd28: q = 7'd81;   7'd29: q = 7'd83;   7'd30: q = 7'd85;   7'd31: q = 7'd88;
      7'd32: q = 7'd90;   7'd33: q = 7'd92;   7'd34: q = 7'd94;   7'd35: q = 7'd96;
      7'd36: q = 7'd98;   7'd37: q = 7'd100;  7'd38: q = 7'd102;  7'd39: q = 7'd104;
      7'd40: q = 7'd106;  7'd41: q = 7'd107;  7'd42: q = 7'd109;  7'd43: q = 7'd111;
      7'd44: q = 7'd112;  7'd45: q = 7'd113;  7'd46: q = 7'd115;  7'd47: q = 7'd116;
      7'd48: q = 7'd117;  7'd49: q = 7'd118;  7'd50: q = 7'd120;  7'd51: q = 7'd121;
      7'd52: q = 7'd122;  7'd53: q = 7'd122;  7'd54: q = 7'd123;  7'd55: q = 7'd124;
      7'd56: q = 7'd125;  7'd57: q = 7'd125;  7'd58: q = 7'd126;  7'd59: q = 7'd126;
      7'd60: q = 7'd126;  7'd61: q = 7'd127;  7'd62: q = 7'd127;  7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction

  // Sample tick and phase carry; the carry marks a period boundary.
  assign w_tick      = (r_state != S_IDLE) && (r_cnt == CNT_W'(FRE_DIV));
  assign w_phase_sum = {1'b0, r_phase} + {1'b0, r_fw};
  assign w_wrap      = w_tick & w_phase_sum[PHASE_W];

  assign sample_en         = w_tick;
  assign busy              = (r_state != S_IDLE);
  assign data_valid        = r_dv;
  assign data_out_unsigned = N'(r_dout);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and the two parameter-load strobes (start, period boundary in RUN).
  always_comb begin
    w_state_nxt  = r_state;
    w_load_start = 1'b0;
    w_load_wrap  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_RUN;
          w_load_start = 1'b1;
        end
      end
      S_RUN: begin
        if (w_wrap) w_load_wrap = 1'b1;
        if (stop)   w_state_nxt = S_STOPPING;
      end
      S_STOPPING: begin
        if (w_wrap) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tick divider: counts 0..FRE_DIV while busy, restarts on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (w_load_start || w_tick) r_cnt <= '0;
    else if (r_state != S_IDLE)      r_cnt <= r_cnt + 1'b1;
  end

  // Phase accumulator advances once per tick, after the lookup has used the old phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_phase <= '0;
    else if (w_load_start) r_phase <= '0;
    else if (w_tick)       r_phase <= w_phase_sum[PHASE_W-1:0];
  end

  // Waveform parameters change only on start or at a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fw  <= '0;
      r_amp <= '0;
      r_dc  <= '0;
`ifdef WAVE_GEN_SQUARE_EN
      r_sel <= 1'b0;
`endif
    end else if (w_load_start || w_load_wrap) begin
      r_fw  <= freq_word;
      r_amp <= amplitude;
      r_dc  <= dc_offset;
`ifdef WAVE_GEN_SQUARE_EN
      r_sel <= wave_sel;
`endif
    end
  end

  // Mirror the quarter table into a full signed period (-127..127).
  assign w_idx = r_phase[PHASE_W-1 -: 8];
  assign w_qk  = w_idx[6] ? (7'd0 - w_idx[6:0]) : w_idx[6:0];
  assign w_mag = f_quarter(w_qk);
  assign w_lut = w_idx[7] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});

  // Stage 1: capture lookup and the parameters of the same sample, so a reload at the wrap cannot leak into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_sin <= '0;
      r_s1_amp <= '0;
      r_s1_dc  <= '0;
`ifdef WAVE_GEN_SQUARE_EN
      r_s1_sq  <= 1'b0;
      r_s1_msb <= 1'b0;
`endif
    end else begin
      r_s1_vld <= w_tick;
      if (w_tick) begin
        r_s1_sin <= w_lut;
        r_s1_amp <= r_amp;
        r_s1_dc  <= r_dc;
`ifdef WAVE_GEN_SQUARE_EN
        r_s1_sq  <= r_sel;
        r_s1_msb <= r_phase[PHASE_W-1];
`endif
      end
    end
  end

  // Scale by amplitude/128 (arithmetic shift floors negatives) and add the DC level.
  assign w_amp_x   = {9'd0, r_s1_amp};
  assign w_sin_x   = {{9{r_s1_sin[7]}}, r_s1_sin};
  assign w_prod    = w_amp_x * w_sin_x;
  assign w_scaled  = w_prod >>> 7;
  assign w_sin_val = $signed({9'd0, r_s1_dc}) + w_scaled;

`ifdef WAVE_GEN_SQUARE_EN
  assign w_sq_val = r_s1_msb ? ($signed({9'd0, r_s1_dc}) - $signed({9'd0, r_s1_amp}))
                             : ($signed({9'd0, r_s1_dc}) + $signed({9'd0, r_s1_amp}));
  assign w_val    = r_s1_sq ? w_sq_val : w_sin_val;
`else
  assign w_val    = w_sin_val;
`endif

  // Clamp to the unsigned 8-bit output range.
  always_comb begin
    w_sat = w_val[7:0];
    if (w_val < 17'sd0)        w_sat = 8'd0;
    else if (w_val > 17'sd255) w_sat = 8'hFF;
  end

  // Stage 2: register the sample; once idle and flushed, park the output on the DC level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dv   <= 1'b0;
      r_dout <= '0;
    end else begin
      r_dv <= r_s1_vld;
      if (r_s1_vld)               r_dout <= w_sat;
      else if (r_state == S_IDLE) r_dout <= r_dc;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: randomized and directed stimulus for wave_gen, checked against a per-sample arithmetic model.
// Latency: expects first data_valid FRE_DIV+3 clocks after start, then every FRE_DIV+1 clocks.
// Backpressure: none; the bench consumes every sample as it appears.
module tb_wave_gen;

  localparam int N  = 8;
  localparam int PW = 24;
  localparam int FD = 4;
`ifdef WAVE_GEN_SQUARE_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [PW-1:0] freq_word = '0;
  logic [7:0]    amplitude = '0;
  logic [7:0]    dc_offset = '0;
  logic          wave_sel = 1'b0;
  logic          sample_en;
  logic [N-1:0]  data_out_unsigned;
  logic          data_valid;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_se = -100;
  int got_q[$];

  wave_gen #(.N(N), .PHASE_W(PW), .FRE_DIV(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .freq_word(freq_word), .amplitude(amplitude), .dc_offset(dc_offset), .wave_sel(wave_sel),
    .sample_en(sample_en), .data_out_unsigned(data_out_unsigned), .data_valid(data_valid), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sample_en) last_se <= cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sine_ref(int k);
    real a;
    a = 2.0 * 3.14159265358979 * real'(k) / 256.0;
    return int'($floor(127.0 * $sin(a) + 0.5));
  endfunction

  function automatic int model_sample(int ph, int amp, int dc, bit sq);
    int s, v;
    s = sine_ref((ph >> 16) & 255);
    v = dc + int'($floor(real'(amp * s) / 128.0));
    if (sq) v = ph[23] ? (dc - amp) : (dc + amp);
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4 * (FD + 1) + 4; k++) begin
      @(negedge clk);
      if (data_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_case(input string nm, input int fw, input int amp, input int dc, input bit sel,
                          input int stop_at, input int chg_at, input int chg_amp, input bit rnd);
    int ph, m_fw, m_amp, m_dc, c0, prev, i, exp_v, bad;
    bit m_sel, stopping, done, ok, pulse_stop, pulse_start;
    longint sum;
    got_q.delete();
    @(negedge clk);
    freq_word = fw[PW-1:0];
    amplitude = amp[7:0];
    dc_offset = dc[7:0];
    wave_sel  = sel;
    start     = 1'b1;
    stop      = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    c0        = cyc;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    ph = 0; m_fw = fw; m_amp = amp; m_dc = dc; m_sel = sel;
    stopping = 1'b0; done = 1'b0; i = 0; prev = c0;
    while (!done && i < 400) begin
      wait_valid(ok);
      chk($sformatf("%s valid_seen s%0d", nm, i), 32'(ok), 1);
      if (!ok) return;
      chk($sformatf("%s gap s%0d", nm, i), cyc - prev, (i == 0) ? FD + 3 : FD + 1);
      chk($sformatf("%s se_to_dv s%0d", nm, i), cyc - last_se, 2);
      exp_v = model_sample(ph, m_amp, m_dc, SQ_EN & m_sel);
      chk($sformatf("%s sample%0d", nm, i), 32'(data_out_unsigned), exp_v);
      got_q.push_back(int'(data_out_unsigned));
      prev = cyc;
      sum = longint'(ph) + longint'(m_fw);
      ph  = int'(sum % (longint'(1) << PW));
      if (sum >= (longint'(1) << PW)) begin
        if (stopping) done = 1'b1;
        else begin
          m_fw  = int'(freq_word);
          m_amp = int'(amplitude);
          m_dc  = int'(dc_offset);
          m_sel = wave_sel;
        end
      end
      if (!done) begin
        if (i == chg_at) amplitude = chg_amp[7:0];
        if (rnd && $urandom_range(0, 7) == 0) begin
          freq_word = PW'($urandom_range(32'h60000, 32'hFFFFFF));
          amplitude = 8'($urandom_range(0, 255));
          dc_offset = 8'($urandom_range(0, 255));
          wave_sel  = 1'($urandom_range(0, 1));
        end
        pulse_stop  = (i == stop_at);
        pulse_start = rnd && ($urandom_range(0, 3) == 0);
        if (pulse_stop || pulse_start) begin
          stop  = pulse_stop;
          start = pulse_start;
          @(negedge clk);
          stop  = 1'b0;
          start = 1'b0;
          if (pulse_stop) stopping = 1'b1;
        end
      end
      i++;
    end
    chk({nm, " finished"}, 32'(done), 1);
    chk({nm, " busy_low"}, 32'(busy), 0);
    @(negedge clk);
    chk({nm, " idle_dc"}, 32'(data_out_unsigned), m_dc);
    bad = 0;
    for (int k = 0; k < 3 * (FD + 1); k++) begin
      @(negedge clk);
      if (data_valid || sample_en || busy || (int'(data_out_unsigned) != m_dc)) bad++;
    end
    chk({nm, " idle_hold"}, bad, 0);
  endtask

  initial begin
    int bad;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst sample_en", 32'(sample_en), 0);
    chk("rst data_valid", 32'(data_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst data_out", 32'(data_out_unsigned), 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || sample_en || data_valid) bad++;
    end
    chk("post_rst idle", bad, 0);

    // sine, amplitude 25, DC 40
    run_case("sine25", 32'h080000, 25, 40, 1'b0, 0, -1, 0, 1'b0);
    chk("sine25 count", got_q.size(), 32);
    chk("sine25 s0", got_q[0], 40);
    chk("sine25 s8", got_q[8], 64);
    chk("sine25 s24", got_q[24], 15);

    // saturation both ends
    run_case("sat200", 32'h080000, 200, 200, 1'b0, 0, -1, 0, 1'b0);
    chk("sat200 s8", got_q[8], 255);
    chk("sat200 s24", got_q[24], 1);

    // wave_sel=1: square with the option, sine otherwise
    run_case("sel1", 32'h080000, 40, 40, 1'b1, 0, -1, 0, 1'b0);
`ifdef WAVE_GEN_SQUARE_EN
    chk("sel1 s0", got_q[0], 80);
    chk("sel1 s15", got_q[15], 80);
    chk("sel1 s16", got_q[16], 0);
    chk("sel1 s31", got_q[31], 0);
`else
    chk("sel1 s0", got_q[0], 40);
    chk("sel1 s8", got_q[8], 79);
    chk("sel1 s24", got_q[24], 0);
`endif

    // stop at sample 10 finishes the period
    run_case("stop10", 32'h080000, 25, 40, 1'b0, 10, -1, 0, 1'b0);
    chk("stop10 count", got_q.size(), 32);
    chk("stop10 held_dc", 32'(data_out_unsigned), 40);

    // amplitude change mid-period takes effect next period
    run_case("chg13", 32'h080000, 25, 40, 1'b0, 40, 5, 13, 1'b0);
    chk("chg13 s8", got_q[8], 64);
    chk("chg13 s24", got_q[24], 15);
    chk("chg13 p1s8", got_q[40], 52);

    // asynchronous reset mid-run
    @(negedge clk);
    freq_word = 24'h080000; amplitude = 8'd25; dc_offset = 8'd40; wave_sel = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (23) @(negedge clk);
    chk("pre_rst busy", 32'(busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst sample_en", 32'(sample_en), 0);
    chk("midrst data_valid", 32'(data_valid), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst data_out", 32'(data_out_unsigned), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (sample_en || busy || data_valid) bad++;
    end
    chk("midrst stays_idle", bad, 0);

    // randomized runs with mid-run parameter changes, spurious starts, start+stop together
    for (int r = 0; r < 6; r++) begin
      run_case($sformatf("rnd%0d", r), int'($urandom_range(32'h60000, 32'hFFFFFF)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 40)), -1, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
